// File: rtl/reg_dump_if.sv
// reg_dump_if: bus between the register dump reader and its environment.
//   start         : request a dump (environment -> reader)
//   Read_register : register-file read address (reader -> register file)
//   Read_data     : combinational read data for Read_register
//   out_valid/out_ready/out_index/out_data : beat stream to downstream
//   busy, done    : status (done is a one-cycle completion pulse)
// modport master = the reader, modport slave = the environment.
interface reg_dump_if;
  logic        start;
  logic [4:0]  Read_register;
  logic [31:0] Read_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  modport master (
    input  start, Read_data, out_ready,
    output Read_register, out_valid, out_index, out_data, busy, done
  );
  modport slave (
    output start, Read_data, out_ready,
    input  Read_register, out_valid, out_index, out_data, busy, done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices FIRST_REG..LAST_REG through a
// register-file read port and streams each (index, value) as a ready/valid
// beat. One register is read per READ cycle, then held in SEND until the
// handshake completes, so a dump runs at one beat per two cycles.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : reg_dump_if.master (start, Read_register, Read_data, out_valid,
//           out_ready, out_index, out_data, busy, done)
//
// Parameters: FIRST_REG (1..LAST_REG), LAST_REG (FIRST_REG..31).
// Optional macro REG_DUMP_SKIP_ZERO_EN: registers reading as zero produce
// no beat and cost a single cycle each.
//
// All outputs are registered.
module reg_dump_reader #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic       clk,
  input  logic       reset,
  reg_dump_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_t      r_state;
  logic [4:0]  r_addr;
  logic [4:0]  r_rd_reg;
  logic [4:0]  r_out_index;
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_done;

  logic        w_last;
  logic        w_hs;
  logic        w_skip;
  logic [4:0]  w_addr_nxt;

  assign w_last     = (r_addr == LAST);
  assign w_hs       = r_out_valid & bus.out_ready;
  assign w_addr_nxt = r_addr + 5'd1;

`ifdef REG_DUMP_SKIP_ZERO_EN
  assign w_skip = (bus.Read_data == 32'd0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= FIRST;
      r_rd_reg    <= 5'd0;
      r_out_index <= 5'd0;
      r_out_data  <= 32'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state  <= READ;
            r_addr   <= FIRST;
            r_rd_reg <= FIRST;
            r_busy   <= 1'b1;
          end
        end
        READ: begin
          if (w_skip) begin
            // Zero register: no beat, move straight to the next index.
            if (w_last) begin
              r_state  <= DONE;
              r_rd_reg <= 5'd0;
              r_done   <= 1'b1;
            end else begin
              r_addr   <= w_addr_nxt;
              r_rd_reg <= w_addr_nxt;
            end
          end else begin
            r_out_data  <= bus.Read_data;
            r_out_index <= r_addr;
            r_out_valid <= 1'b1;
            r_rd_reg    <= 5'd0;
            r_state     <= SEND;
          end
        end
        SEND: begin
          // Beat is frozen until accepted; addr never passes LAST.
          if (w_hs) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= READ;
              r_addr   <= w_addr_nxt;
              r_rd_reg <= w_addr_nxt;
            end
          end
        end
        DONE: begin
          // start is ignored here; always return to IDLE.
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= FIRST;
        end
        default: begin
          r_state     <= IDLE;
          r_rd_reg    <= 5'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Read_register = r_rd_reg;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_index     = r_out_index;
  assign bus.out_data      = r_out_data;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule
